alu_seq_ctrl: RTL

Button-driven operand/opcode sequencer and execution controller for the board-level ALU. It edge-detects raw push-buttons, shifts bits into an entry register, latches operand A, operand B and a 3-bit opcode in turn, then executes the operation. Single-cycle ops finish in one cycle; the optional multiply is a multi-cycle shift-add. It sits between the `top` pb inputs and the left/right LEDs and ssdec displays.

---
 rtl/alu_seq_ctrl_if.sv | 26 ++
 rtl/alu_seq_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Button inputs and display outputs of the ALU sequencer, grouped as one bundle.
// slave = sequencer side, master = board/bench side.
interface alu_seq_ctrl_if #(parameter int WIDTH = 8);
    logic             pb_zero;
    logic             pb_one;
    logic             pb_next;
    logic             pb_clear;
    logic [WIDTH-1:0] entry;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             err;
    logic [2:0]       state;
    logic             busy;
    logic             done;

    modport slave (
        input  pb_zero, pb_one, pb_next, pb_clear,
        output entry, result, carry, zero, err, state, busy, done
    );

    modport master (
        output pb_zero, pb_one, pb_next, pb_clear,
        input  entry, result, carry, zero, err, state, busy, done
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Push-button operand/opcode sequencer and ALU execution controller.
// Optional feature macro: ALU_MUL_EN (opcode 7 = iterative shift-add multiply).
module alu_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           hz100,
    input  logic           reset,
    alu_seq_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_B  = 3'd1,
        ENTER_OP = 3'd2,
        EXEC     = 3'd3,
        SHOW     = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       prev_q, pb, pulse;
    logic             clr, nxt, p0, p1, exec_fin;
    logic [WIDTH-1:0] entry_q, entry_d, a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d, zero_q, zero_d, err_q, err_d, done_q, done_d;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_err;

    // Rising edge = pressed this cycle and not last cycle.
    assign pb    = {bus.pb_clear, bus.pb_next, bus.pb_one, bus.pb_zero};
    assign pulse = pb & ~prev_q;
    assign clr   = pulse[3];
    assign nxt   = pulse[2];
    assign p1    = pulse[1];
    assign p0    = pulse[0];

`ifdef ALU_MUL_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, partial, mul_sum;
    logic               is_mul;

    assign is_mul   = (op_q == 3'd7);
    assign partial  = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    assign mul_sum  = acc_q + partial;
    assign exec_fin = !is_mul || (cnt_q == CW'(WIDTH - 1));
`else
    assign exec_fin = 1'b1;
`endif

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) state_q <= ENTER_A;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ENTER_A:  if (nxt) state_d = ENTER_B;
            ENTER_B:  if (nxt) state_d = ENTER_OP;
            ENTER_OP: if (nxt) state_d = EXEC;
            EXEC:     if (exec_fin) state_d = SHOW;
            SHOW:     if (nxt) state_d = ENTER_A;
            default:  state_d = ENTER_A;
        endcase
        if (clr) state_d = ENTER_A;
    end

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_err = 1'b0;
        case (op_q)
            3'd0: {alu_c, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            3'd1: begin alu_res = a_q - b_q; alu_c = (a_q < b_q); end
            3'd2: alu_res = a_q & b_q;
            3'd3: alu_res = a_q | b_q;
            3'd4: alu_res = a_q ^ b_q;
            3'd5: begin alu_res = {a_q[WIDTH-2:0], 1'b0}; alu_c = a_q[WIDTH-1]; end
            3'd6: begin alu_res = {1'b0, a_q[WIDTH-1:1]}; alu_c = a_q[0]; end
            default: begin
`ifdef ALU_MUL_EN
                alu_res = mul_sum[WIDTH-1:0];
                alu_c   = |mul_sum[2*WIDTH-1:WIDTH];
`else
                alu_err = 1'b1;
`endif
            end
        endcase
    end

    always_comb begin
        entry_d  = entry_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        err_d    = err_q;
        done_d   = 1'b0;
`ifdef ALU_MUL_EN
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        if (clr) begin
            entry_d  = '0;
            a_d      = '0;
            b_d      = '0;
            op_d     = '0;
            result_d = '0;
            carry_d  = 1'b0;
            zero_d   = 1'b0;
            err_d    = 1'b0;
`ifdef ALU_MUL_EN
            acc_d    = '0;
            cnt_d    = '0;
`endif
        end else begin
            case (state_q)
                ENTER_A, ENTER_B, ENTER_OP: begin
                    if (nxt) begin
                        if (state_q == ENTER_A)      a_d  = entry_q;
                        else if (state_q == ENTER_B) b_d  = entry_q;
                        else                         op_d = entry_q[2:0];
                        entry_d = '0;
                    end else if (p0 ^ p1) begin
                        entry_d = {entry_q[WIDTH-2:0], p1};
                    end
                end
                EXEC: begin
`ifdef ALU_MUL_EN
                    if (is_mul) begin
                        acc_d = mul_sum;
                        cnt_d = cnt_q + CW'(1);
                    end
`endif
                    if (exec_fin) begin
                        result_d = alu_res;
                        carry_d  = alu_c;
                        zero_d   = (alu_res == '0);
                        err_d    = alu_err;
                        done_d   = 1'b1;
`ifdef ALU_MUL_EN
                        // Leave the multiplier idle-clean for the next EXEC.
                        acc_d    = '0;
                        cnt_d    = '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            prev_q   <= '0;
            entry_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
`ifdef ALU_MUL_EN
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            prev_q   <= pb;
            entry_q  <= entry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            done_q   <= done_d;
`ifdef ALU_MUL_EN
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    always_comb begin
        bus.state  = state_q;
        bus.busy   = (state_q == EXEC);
        bus.done   = done_q;
        bus.entry  = entry_q;
        bus.result = result_q;
        bus.carry  = carry_q;
        bus.zero   = zero_q;
        bus.err    = err_q;
    end
endmodule
